// File: rtl/xs_arb_pkg.sv
// xs_arb_pkg: shared types and constants for the memory port arbiter
package xs_arb_pkg;
    localparam int PERF_CNT_W = 32;
    // Read-tag id width covers the largest supported requester count (8)
    localparam int RD_ID_W = 3;
    typedef enum logic {WAIT_INIT, RUN} arb_state_e;
    typedef struct packed {
        logic               valid;
        logic [RD_ID_W-1:0] id;
    } rd_tag_t;
endpackage

// File: rtl/xs_mem_port_arbiter_if.sv
// xs_mem_port_arbiter_if: requester and DPI memory port signals of the arbiter
interface xs_mem_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 64,
    parameter int DATA_W  = 64
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*IDX_W-1:0]  req_index;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*DATA_W-1:0] req_wmask;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      mem_r_enable;
    logic [IDX_W-1:0]          mem_r_index;
    logic [DATA_W-1:0]         mem_r_data;
    logic                      mem_w_enable;
    logic [IDX_W-1:0]          mem_w_index;
    logic [DATA_W-1:0]         mem_w_data;
    logic [DATA_W-1:0]         mem_w_mask;
    modport slave (
        input  req_valid, req_write, req_index, req_wdata, req_wmask, mem_r_data,
        output req_ready, rsp_valid, rsp_data, mem_r_enable, mem_r_index,
               mem_w_enable, mem_w_index, mem_w_data, mem_w_mask
    );
    modport master (
        output req_valid, req_write, req_index, req_wdata, req_wmask, mem_r_data,
        input  req_ready, rsp_valid, rsp_data, mem_r_enable, mem_r_index,
               mem_w_enable, mem_w_index, mem_w_data, mem_w_mask
    );
endinterface

// File: rtl/xs_rr_pick.sv
// xs_rr_pick: combinational round-robin picker, first set request at or above ptr (wrapping)
module xs_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    // Scan offsets from farthest to nearest so the nearest set request wins
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[IW'((int'(ptr) + k) % N)]) begin
                gnt = N'(1) << ((int'(ptr) + k) % N);
                idx = IW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/xs_mem_port_arbiter.sv
// xs_mem_port_arbiter: round-robin sharing of one DPI read/write port pair; XS_ARB_PERF_EN adds grant counters
module xs_mem_port_arbiter
    import xs_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int IDX_W    = 64,
    parameter int DATA_W   = 64,
    parameter int READ_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic init_done,
    xs_mem_port_arbiter_if.slave bus,
`ifdef XS_ARB_PERF_EN
    input  logic perf_clr,
    output logic [NUM_REQ*PERF_CNT_W-1:0] perf_grant_cnt,
`endif
    output logic busy
);
    localparam int IW = $clog2(NUM_REQ);

    arb_state_e                  state_q, state_d;
    logic [IW-1:0]               rr_ptr_q, rr_ptr_d, pick_idx;
    logic [NUM_REQ-1:0]          pick_gnt, ready, hs_vec;
    logic                        hs, hs_wr;
    logic                        mem_r_enable_q, mem_r_enable_d, mem_w_enable_q, mem_w_enable_d;
    logic [IDX_W-1:0]            mem_r_index_q, mem_r_index_d, mem_w_index_q, mem_w_index_d;
    logic [DATA_W-1:0]           mem_w_data_q, mem_w_data_d, mem_w_mask_q, mem_w_mask_d;
    rd_tag_t                     iss_q, iss_d;
    rd_tag_t [READ_LAT-1:0]      sr_q, sr_d;
    logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]           rsp_data_q, rsp_data_d;

    xs_rr_pick #(.N(NUM_REQ)) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign ready  = (state_q == RUN && enable) ? pick_gnt : '0;
    assign hs_vec = bus.req_valid & ready;
    assign hs     = |hs_vec;
    assign hs_wr  = bus.req_write[pick_idx];

    // Next-state: FSM, pointer advance, issue stage and read-return pipeline
    always_comb begin
        state_d        = !init_done ? WAIT_INIT : (enable ? RUN : state_q);
        rr_ptr_d       = hs ? IW'((int'(pick_idx) + 1) % NUM_REQ) : rr_ptr_q;
        mem_w_enable_d = hs & hs_wr;
        mem_r_enable_d = hs & ~hs_wr;
        mem_w_index_d  = mem_w_enable_d ? bus.req_index[int'(pick_idx)*IDX_W +: IDX_W] : mem_w_index_q;
        mem_w_data_d   = mem_w_enable_d ? bus.req_wdata[int'(pick_idx)*DATA_W +: DATA_W] : mem_w_data_q;
        mem_w_mask_d   = mem_w_enable_d ? bus.req_wmask[int'(pick_idx)*DATA_W +: DATA_W] : mem_w_mask_q;
        mem_r_index_d  = mem_r_enable_d ? bus.req_index[int'(pick_idx)*IDX_W +: IDX_W] : mem_r_index_q;
        iss_d.valid    = mem_r_enable_d;
        iss_d.id       = RD_ID_W'(pick_idx);
        sr_d           = sr_q;
        sr_d[0]        = iss_q;
        for (int k = 1; k < READ_LAT; k++) sr_d[k] = sr_q[k-1];
        rsp_valid_d    = sr_q[READ_LAT-1].valid ? NUM_REQ'(1) << sr_q[READ_LAT-1].id : '0;
        rsp_data_d     = sr_q[READ_LAT-1].valid ? bus.mem_r_data : rsp_data_q;
    end

    // Register all state; reset drops anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= WAIT_INIT;
            rr_ptr_q       <= '0;
            mem_r_enable_q <= 1'b0;
            mem_w_enable_q <= 1'b0;
            mem_r_index_q  <= '0;
            mem_w_index_q  <= '0;
            mem_w_data_q   <= '0;
            mem_w_mask_q   <= '0;
            iss_q          <= '0;
            sr_q           <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            mem_r_enable_q <= mem_r_enable_d;
            mem_w_enable_q <= mem_w_enable_d;
            mem_r_index_q  <= mem_r_index_d;
            mem_w_index_q  <= mem_w_index_d;
            mem_w_data_q   <= mem_w_data_d;
            mem_w_mask_q   <= mem_w_mask_d;
            iss_q          <= iss_d;
            sr_q           <= sr_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
        end
    end

    // A read is in flight while any issue or return stage holds a valid tag
    always_comb begin
        busy = iss_q.valid;
        for (int k = 0; k < READ_LAT; k++) busy = busy | sr_q[k].valid;
    end

    assign bus.req_ready    = ready;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.mem_r_enable = mem_r_enable_q;
    assign bus.mem_r_index  = mem_r_index_q;
    assign bus.mem_w_enable = mem_w_enable_q;
    assign bus.mem_w_index  = mem_w_index_q;
    assign bus.mem_w_data   = mem_w_data_q;
    assign bus.mem_w_mask   = mem_w_mask_q;

`ifdef XS_ARB_PERF_EN
    logic [NUM_REQ-1:0][PERF_CNT_W-1:0] cnt_q, cnt_d;

    // Saturating per-requester handshake counters; clear wins over increment
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            cnt_d[i] = perf_clr ? '0 : ((hs_vec[i] && !(&cnt_q[i])) ? cnt_q[i] + 1'b1 : cnt_q[i]);
    end

    // Counter storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign perf_grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_xs_mem_port_arbiter.sv
// tb_xs_mem_port_arbiter: scoreboard bench with a DPI memory model; covers XS_ARB_PERF_EN when defined
module tb_xs_mem_port_arbiter;
    localparam int NR = 4;
    localparam int XW = 64;
    localparam int DW = 64;
    localparam int RL = 3;

    typedef struct {
        int          id;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic init_done = 1'b0;
    logic busy;
`ifdef XS_ARB_PERF_EN
    logic perf_clr = 1'b0;
    logic [NR*32-1:0] perf_grant_cnt;
`endif

    xs_mem_port_arbiter_if #(.NUM_REQ(NR), .IDX_W(XW), .DATA_W(DW)) bus ();

    xs_mem_port_arbiter #(.NUM_REQ(NR), .IDX_W(XW), .DATA_W(DW), .READ_LAT(RL)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .init_done      (init_done),
        .bus            (bus),
`ifdef XS_ARB_PERF_EN
        .perf_clr       (perf_clr),
        .perf_grant_cnt (perf_grant_cnt),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t sb[$];
    int gnt_log[$];
    logic [63:0] dpi_mem [logic [63:0]];
    logic [63:0] model_mem [logic [63:0]];
    logic [63:0] idx_pipe [RL];

    function automatic logic [63:0] rd_dpi(logic [63:0] a);
        return dpi_mem.exists(a) ? dpi_mem[a] : 64'h0;
    endfunction

    function automatic logic [63:0] rd_model(logic [63:0] a);
        return model_mem.exists(a) ? model_mem[a] : 64'h0;
    endfunction

    always @(posedge clk) cyc++;

    // DPI memory: masked writes, read data valid RL cycles after mem_r_enable
    always @(posedge clk) begin
        if (bus.mem_w_enable)
            dpi_mem[bus.mem_w_index] = (rd_dpi(bus.mem_w_index) & ~bus.mem_w_mask) | (bus.mem_w_data & bus.mem_w_mask);
        for (int k = RL - 1; k > 0; k--) idx_pipe[k] = idx_pipe[k-1];
        idx_pipe[0] = bus.mem_r_index;
        bus.mem_r_data <= rd_dpi(idx_pipe[RL-1]);
    end

    // Scoreboard: record handshakes, predict responses, check them on arrival
    always @(negedge clk) begin
        logic [NR-1:0] hs;
        exp_t e;
        logic [63:0] a;
        hs = bus.req_valid & bus.req_ready;
        if (!rst_n) sb.delete();
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) begin
                gnt_log.push_back(i);
                a = bus.req_index[i*XW +: XW];
                if (bus.req_write[i])
                    model_mem[a] = (rd_model(a) & ~bus.req_wmask[i*DW +: DW]) | (bus.req_wdata[i*DW +: DW] & bus.req_wmask[i*DW +: DW]);
                else
                    sb.push_back('{i, rd_model(a), cyc + RL + 2});
            end
        end
        if (bus.rsp_valid != '0) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected rsp_valid=%b expected none", bus.rsp_valid);
            end else begin
                e = sb.pop_front();
                if (bus.rsp_valid !== (NR'(1) << e.id) || bus.rsp_data !== e.data || cyc != e.due) begin
                    failures++;
                    $display("FAIL rsp got valid=%b data=%h cyc=%0d expected valid=%b data=%h cyc=%0d",
                             bus.rsp_valid, bus.rsp_data, cyc, NR'(1) << e.id, e.data, e.due);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && (sb.size() != 0 || busy); n++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        init_done = 1'b0;
        enable = 1'b1;
        bus.req_valid = '1;
        bus.req_write = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        for (int i = 0; i < NR; i++) bus.req_index[i*XW +: XW] = 64'h100 + 64'(i);
        repeat (2) step();
        checks++;
        if ({bus.req_ready, bus.mem_r_enable, bus.mem_w_enable, bus.rsp_valid, busy} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got ready=%b r_en=%b w_en=%b rsp=%b busy=%b expected all 0",
                     bus.req_ready, bus.mem_r_enable, bus.mem_w_enable, bus.rsp_valid, busy);
        end
        checks++;
        if ({bus.mem_r_index, bus.mem_w_index, bus.mem_w_data, bus.mem_w_mask, bus.rsp_data} !== '0) begin
            failures++;
            $display("FAIL reset_data got r_idx=%h w_idx=%h w_data=%h w_mask=%h rsp_data=%h expected 0",
                     bus.mem_r_index, bus.mem_w_index, bus.mem_w_data, bus.mem_w_mask, bus.rsp_data);
        end
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.req_ready !== '0 || bus.mem_r_enable !== 1'b0) begin
            failures++;
            $display("FAIL init_gate got ready=%b r_en=%b expected 0000 0", bus.req_ready, bus.mem_r_enable);
        end
        init_done = 1'b1;
        step();
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL first_grant got ready=%b expected 0001", bus.req_ready);
        end
        step();
        bus.req_valid = '0;
        checks++;
        if (bus.mem_r_enable !== 1'b1 || bus.mem_r_index !== 64'h100 || busy !== 1'b1) begin
            failures++;
            $display("FAIL first_issue got r_en=%b idx=%h busy=%b expected 1 100 1", bus.mem_r_enable, bus.mem_r_index, busy);
        end
        step();
        checks++;
        if (bus.mem_r_enable !== 1'b0) begin
            failures++;
            $display("FAIL issue_pulse got r_en=%b expected 0", bus.mem_r_enable);
        end
    endtask

    task automatic test_round_robin();
        int exp_o[5] = '{0, 1, 2, 3, 0};
        drain();
        rst_n = 1'b0;
        step();
        gnt_log.delete();
        rst_n = 1'b1;
        bus.req_write = '0;
        bus.req_valid = '1;
        for (int n = 0; n < 20 && gnt_log.size() < 5; n++) step();
        bus.req_valid = '0;
        checks++;
        if (gnt_log.size() != 5) begin
            failures++;
            $display("FAIL rr_count got %0d expected 5", gnt_log.size());
        end
        for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
            checks++;
            if (gnt_log[i] != exp_o[i]) begin
                failures++;
                $display("FAIL rr_order[%0d] got %0d expected %0d", i, gnt_log[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_write_read();
        int n = 0;
        drain();
        bus.req_write = 4'b0100;
        bus.req_index[2*XW +: XW] = 64'h10;
        bus.req_wdata[2*DW +: DW] = 64'hDEAD_BEEF_0000_1234;
        bus.req_wmask[2*DW +: DW] = '1;
        bus.req_valid = 4'b0100;
        #1;
        while (!bus.req_ready[2] && n < 10) begin step(); n++; end
        checks++;
        if (!bus.req_ready[2]) begin
            failures++;
            $display("FAIL wr_grant got ready=%b expected 0100", bus.req_ready);
        end
        step();
        bus.req_valid = 4'b0010;
        bus.req_write = '0;
        bus.req_index[1*XW +: XW] = 64'h10;
        checks++;
        if ({bus.mem_w_enable, bus.mem_r_enable} !== 2'b10) begin
            failures++;
            $display("FAIL wr_enables got w=%b r=%b expected 1 0", bus.mem_w_enable, bus.mem_r_enable);
        end
        checks++;
        if (bus.mem_w_index !== 64'h10 || bus.mem_w_data !== 64'hDEAD_BEEF_0000_1234 || bus.mem_w_mask !== '1) begin
            failures++;
            $display("FAIL wr_fields got idx=%h data=%h mask=%h expected 10 deadbeef00001234 ffffffffffffffff",
                     bus.mem_w_index, bus.mem_w_data, bus.mem_w_mask);
        end
        step();
        bus.req_valid = '0;
        checks++;
        if (bus.mem_w_enable !== 1'b0 || bus.mem_r_enable !== 1'b1 || bus.mem_r_index !== 64'h10) begin
            failures++;
            $display("FAIL rd_issue got w=%b r=%b idx=%h expected 0 1 10", bus.mem_w_enable, bus.mem_r_enable, bus.mem_r_index);
        end
        n = 0;
        while (!bus.rsp_valid[1] && n < 10) begin step(); n++; end
        checks++;
        if (bus.rsp_valid[1] !== 1'b1 || bus.rsp_data !== 64'hDEAD_BEEF_0000_1234) begin
            failures++;
            $display("FAIL raw_data got valid=%b data=%h expected 1 deadbeef00001234", bus.rsp_valid[1], bus.rsp_data);
        end
    endtask

    task automatic test_enable_drop();
        int n0;
        drain();
        bus.req_write = '0;
        for (int i = 0; i < 3; i++) bus.req_index[i*XW +: XW] = 64'h100 + 64'(i);
        n0 = gnt_log.size();
        bus.req_valid = 4'b0111;
        repeat (3) step();
        enable = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== '0) begin
            failures++;
            $display("FAIL en_drop_ready got %b expected 0000", bus.req_ready);
        end
        checks++;
        if (gnt_log.size() - n0 != 3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL en_drop_inflight got grants=%0d busy=%b expected 3 1", gnt_log.size() - n0, busy);
        end
        repeat (2) step();
        checks++;
        if (gnt_log.size() - n0 != 3) begin
            failures++;
            $display("FAIL en_drop_hold got grants=%0d expected 3", gnt_log.size() - n0);
        end
        bus.req_valid = '0;
        drain();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL en_drop_drain got pending=%0d expected 0", sb.size());
        end
        enable = 1'b1;
    endtask

    task automatic test_skip_idle();
        drain();
        bus.req_write = '0;
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = 4'b0010;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL skip_grant got %b expected 0010", bus.req_ready);
        end
        step();
        bus.req_valid = 4'b1110;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL skip_ptr got %b expected 0100", bus.req_ready);
        end
        bus.req_valid = '0;
        #1;
    endtask

    task automatic test_init_drop();
        drain();
        bus.req_write = '0;
        init_done = 1'b0;
        bus.req_valid = 4'b0001;
        step();
        checks++;
        if (bus.req_ready !== '0) begin
            failures++;
            $display("FAIL init_drop got ready=%b expected 0000", bus.req_ready);
        end
        init_done = 1'b1;
        step();
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL init_resume got ready=%b expected 0001", bus.req_ready);
        end
        bus.req_valid = '0;
        #1;
    endtask

`ifdef XS_ARB_PERF_EN
    task automatic test_perf();
        drain();
        bus.req_write = '0;
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        bus.req_valid = 4'b0001;
        repeat (5) step();
        bus.req_valid = '0;
        #1;
        checks++;
        if (perf_grant_cnt[31:0] !== 32'd5 || perf_grant_cnt[63:32] !== 32'd0) begin
            failures++;
            $display("FAIL perf_count got c0=%0d c1=%0d expected 5 0", perf_grant_cnt[31:0], perf_grant_cnt[63:32]);
        end
        bus.req_valid = 4'b0001;
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        bus.req_valid = '0;
        #1;
        checks++;
        if (perf_grant_cnt[31:0] !== 32'd0) begin
            failures++;
            $display("FAIL perf_clr got c0=%0d expected 0", perf_grant_cnt[31:0]);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < NR; i++) begin
            dpi_mem[64'h100 + 64'(i)] = 64'hA5A5_0000_1234_5678 ^ (64'(i) << 40) ^ 64'(i * 3);
            model_mem[64'h100 + 64'(i)] = 64'hA5A5_0000_1234_5678 ^ (64'(i) << 40) ^ 64'(i * 3);
        end
        test_reset();
        test_round_robin();
        test_write_read();
        test_enable_drop();
        test_skip_idle();
        test_init_drop();
`ifdef XS_ARB_PERF_EN
        test_perf();
`endif
        drain();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL final_drain got pending=%0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
